// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - two-client arbiter sharing one synchronous single-port RAM
module dpram_port_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 16,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_wen,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             burst_done;
   logic             last_owner;
   logic             xfer0;
   logic             xfer1;

   // Grants are decodes of the state register, so they change only at the clock edge.
   assign gnt0  = (state == OWN0);
   assign gnt1  = (state == OWN1);
   assign xfer0 = gnt0 & req0;
   assign xfer1 = gnt1 & req1;

   // Read data comes straight from the RAM; rvalid marks whose result it is.
   assign rdata = ram_dout;

   // Count including the transfer happening now, so the switch lands right after the last allowed one.
   assign cnt_inc    = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
   assign burst_done = (cnt_inc == CNT_MAX);

   // Next-owner selection; ties from IDLE go to the client that did not own last.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               state_nxt = last_owner ? OWN0 : OWN1;
            end else if (req0) begin
               state_nxt = OWN0;
            end else if (req1) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (req0) begin
               if (req1 && burst_done) begin
                  state_nxt = OWN1;
               end
            end else begin
               state_nxt = req1 ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (req1) begin
               if (req0 && burst_done) begin
                  state_nxt = OWN0;
               end
            end else begin
               state_nxt = req0 ? OWN0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RAM port is steered from whichever client is transferring; idle drive is all zeros.
   always_comb begin
      ram_addr = '0;
      ram_din  = '0;
      ram_wen  = 1'b0;
      if (xfer0) begin
         ram_addr = addr0;
         ram_din  = wdata0;
         ram_wen  = we0 & ~reset;
      end else if (xfer1) begin
         ram_addr = addr1;
         ram_din  = wdata1;
         ram_wen  = we1 & ~reset;
      end
   end

   // Ownership state, burst counter, tie-break history and read-valid pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_owner <= 1'b1;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
      end else begin
         state   <= state_nxt;
         rvalid0 <= xfer0 & ~we0;
         rvalid1 <= xfer1 & ~we1;
         if (state_nxt != state) begin
            burst_cnt <= '0;
         end else if (xfer0 || xfer1) begin
            burst_cnt <= cnt_inc;
         end
         if (state_nxt == OWN0 && state != OWN0) begin
            last_owner <= 1'b0;
         end else if (state_nxt == OWN1 && state != OWN1) begin
            last_owner <= 1'b1;
         end
      end
   end

endmodule

// File: doc/dpram_port_arbiter.md
DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 10, RAM address width
- DATA_W, 16, RAM data width
- BURST_MAX, 4, maximum consecutive transfers by one owner while the other client waits
REQ-002 The clock SHALL be one clock, clk; reset SHALL be synchronous and active-high, reset.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, sync active-high reset
- req0 / req1, in, 1, client n requests one transfer this cycle
- we0 / we1, in, 1, client n transfer is a write (1) or read (0)
- addr0 / addr1, in, ADDR_W, client n address
- wdata0 / wdata1, in, DATA_W, client n write data
- gnt0 / gnt1, out, 1, client n owns the RAM port this cycle (registered)
- rvalid0 / rvalid1, out, 1, rdata holds client n read result (registered)
- rdata, out, DATA_W, read data; equals ram_dout
- ram_addr, out, ADDR_W, to RAM port
- ram_din, out, DATA_W, to RAM port
- ram_wen, out, 1, to RAM port
- ram_dout, in, DATA_W, RAM read data; one-cycle synchronous latency

Function
REQ-004 The state machine SHALL have three states:
- IDLE: no grant
- OWN0: gnt0=1
- OWN1: gnt1=1
- gnt0 and gnt1 SHALL never both be 1.
REQ-005 A transfer by client n SHALL occur in any cycle where gntn=1 and reqn=1.
REQ-006 RAM drive SHALL be combinational from the owning client:
- ram_addr = addrn
- ram_din = wdatan
- ram_wen = reqn & wen & gntn
- With no transfer, ram_wen=0, ram_addr=0 and ram_din=0.
REQ-007 A read transfer by client n in cycle t SHALL produce rvalidn=1 in cycle t+1 only, with rdata = ram_dout in that cycle.
- A write transfer SHALL produce no rvalid.
REQ-008 rvalid for an issued read SHALL be delivered even if the grant changes at the same edge.
REQ-009 Grant latency: a request from IDLE SHALL see gnt at the next clock edge. A transfer cannot occur in the cycle the request first rises from IDLE.
REQ-010 Arbitration SHALL be evaluated every edge.
- From IDLE, req0 only: go to OWN0.
- From IDLE, req1 only: go to OWN1.
- From IDLE, both requesting: grant the client not recorded in last_owner.
REQ-011 In OWNn with reqn=1:
- If the other client is requesting and burst_cnt has reached BURST_MAX, go to OWN(other).
- Otherwise stay in OWNn.
REQ-012 In OWNn with reqn=0: go to OWN(other) if the other client is requesting, else go to IDLE.
REQ-013 burst_cnt SHALL count transfers by the current owner.
- It SHALL reset to 0 on every ownership change.
- It SHALL saturate at BURST_MAX.
- It SHALL reach BURST_MAX on the edge ending the BURST_MAX-th transfer.
REQ-014 last_owner SHALL update to n on every entry to OWNn.
REQ-015 The arbiter SHALL NOT buffer requests. A client SHALL hold req, we, addr and wdata stable until it sees gnt.
REQ-016 Address or data values at range limits (addr 1023, data 16'hFFFF) SHALL pass through unmodified, with no wrap or arithmetic.

Reset
REQ-017 While reset=1 at an edge, the following SHALL hold after that edge:
- state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0
- burst_cnt=0, last_owner=1, so client 0 wins the first tie
REQ-018 A read issued in the cycle reset is asserted SHALL produce no rvalid.
REQ-019 ram_wen SHALL be 0 during any cycle in which reset=1.

Verification
REQ-020 Single read:
- Stimulus: RAM[5]=16'h00AA; req0=1, we0=0, addr0=5 from IDLE.
- Response: gnt0=1 at cycle 1; rvalid0=1 with rdata=16'h00AA at cycle 2; rvalid1=0 throughout.
REQ-021 Tie after reset:
- Stimulus: req0 and req1 rise together after reset.
- Response: gnt0 first. After 4 transfers by client 0, gnt1 on the next cycle; after 4 transfers by client 1, gnt0 again.
REQ-022 Read-then-switch:
- Stimulus: client 0 owns with burst_cnt=3; client 1 requesting; client 0 issues its 4th transfer, a read of addr 9.
- Response: gnt1=1 and rvalid0=1 in the same next cycle, rdata=RAM[9].
REQ-023 Uncontested hold:
- Stimulus: req1 held 10 cycles of writes to addr 0..9, data = addr+1; req0=0.
- Response: gnt1 stays 1 throughout; RAM[0..9]=1..10; burst_cnt saturates at 4.
REQ-024 Release handover:
- Stimulus: client 0 drops req0 while req1=1.
- Response: gnt0=0 and gnt1=1 at the next edge, with no IDLE cycle.
REQ-025 Reset mid-read:
- Stimulus: reset=1 in the cycle client 1 issues a read.
- Response: next cycle gnt0=gnt1=0, rvalid1=0, ram_wen=0.
